// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: radix-2 shift-add
// multiply and restoring divide on operand magnitudes, one bit per cycle.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdStartE,
  input  logic [2:0]      mdOpE,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic [4:0]      rdE,
  input  logic            flushE,
  output logic            stallE,
  output logic            mdDoneE,
  output logic [XLEN-1:0] mdResultE,
  output logic [4:0]      mdRdE
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST    = 6'(XLEN - 1);

  state_t              state, state_nx;
  logic [5:0]          cnt;
  logic [2:0]          op;
  logic                neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [2*XLEN-1:0]   acc, acc_step;

  logic                a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]     abs_a, abs_b, fast_res;
  logic                div_zero, div_ovf, fast, start;
  logic [XLEN:0]       mul_sum, rem_sh;
  logic [XLEN-1:0]     rem_sub;
  logic                can_sub;

  // Sign fixup on the unsigned magnitude result; op[2] selects divide class.
  function automatic logic [XLEN-1:0] fixup(input logic [2:0] f_op, input logic f_na,
                                            input logic f_nb, input logic [2*XLEN-1:0] f_acc);
    logic signed [2*XLEN-1:0] p;
    logic [XLEN-1:0]          q, r, res;
    p = (f_na ^ f_nb) ? -f_acc : f_acc;
    q = (f_na ^ f_nb) ? -f_acc[XLEN-1:0] : f_acc[XLEN-1:0];
    r = f_na ? -f_acc[2*XLEN-1:XLEN] : f_acc[2*XLEN-1:XLEN];
    if (!f_op[2])
      res = (f_op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else
      res = f_op[1] ? r : q;
    return res;
  endfunction

  // Operand decode at start: MULHSU keeps A signed only, unsigned ops drop both.
  assign a_signed = mdOpE[2] ? ~mdOpE[0] : (mdOpE[1:0] != 2'b11);
  assign b_signed = mdOpE[2] ? ~mdOpE[0] : ~mdOpE[1];
  assign sa       = a_signed & srcAE[XLEN-1];
  assign sb       = b_signed & srcBE[XLEN-1];
  assign abs_a    = sa ? -srcAE : srcAE;
  assign abs_b    = sb ? -srcBE : srcBE;
  assign div_zero = mdOpE[2] && (srcBE == '0);
  assign div_ovf  = mdOpE[2] && !mdOpE[0] && (srcAE == MIN_NEG) && (srcBE == '1);
  assign fast     = div_zero || div_ovf;
  assign start    = (state == IDLE) && mdStartE && !flushE;

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = mdOpE[1] ? srcAE : '1;
    else if (div_ovf)
      fast_res = mdOpE[1] ? '0 : MIN_NEG;
  end

  // One iteration: multiply adds A into the high half and shifts right;
  // divide shifts the dividend into the remainder and subtracts when it fits.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    can_sub = rem_sh >= {1'b0, mag_b};
    rem_sub = rem_sh[XLEN-1:0] - mag_b;
    if (op[2])
      acc_step = can_sub ? {rem_sub, acc[XLEN-2:0], 1'b1}
                         : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mdStartE) state_nx = fast ? DONE : CALC;
      CALC:    if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flushE) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mdResultE <= '0;
      mdRdE     <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        cnt   <= '0;
        mdRdE <= rdE;
        if (fast) mdResultE <= fast_res;
      end else if (state == CALC && !flushE) begin
        cnt <= cnt + 6'd1;
        if (cnt == LAST) mdResultE <= fixup(op, neg_a, neg_b, acc_step);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      op    <= mdOpE;
      neg_a <= sa;
      neg_b <= sb;
      mag_a <= abs_a;
      mag_b <= abs_b;
      acc   <= mdOpE[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

  assign mdDoneE = (state == DONE);
  assign stallE  = !rst && !flushE && (((state == IDLE) && mdStartE) || (state == CALC));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: results queued at issue, popped on mdDoneE.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, mdStartE, flushE;
  logic [2:0]  mdOpE;
  logic [31:0] srcAE, srcBE;
  logic [4:0]  rdE;
  logic        stallE, mdDoneE;
  logic [31:0] mdResultE;
  logic [4:0]  mdRdE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dones  = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .mdStartE(mdStartE), .mdOpE(mdOpE), .srcAE(srcAE),
    .srcBE(srcBE), .rdE(rdE), .flushE(flushE), .stallE(stallE), .mdDoneE(mdDoneE),
    .mdResultE(mdResultE), .mdRdE(mdRdE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mdDoneE === 1'b1) begin
      dones++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d got rd=%0d res=%h want no pulse", cyc, mdRdE, mdResultE);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mdRdE, mdResultE} !== mon_e) begin
          errors++;
          $display("FAIL result cyc=%0d got rd=%0d res=%h want rd=%0d res=%h",
                   cyc, mdRdE, mdResultE, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pu  = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int t_start, output int lat, output int stalls);
    @(posedge clk); #1;
    mdOpE = op; srcAE = a; srcBE = b; rdE = rd; mdStartE = 1'b1; flushE = 1'b0;
    t_start = cyc; lat = -1; stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stallE === 1'b1) stalls++;
      if (mdDoneE === 1'b1) begin lat = cyc - t_start; break; end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mdStartE = 1'b0; flushE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mdStartE = 1'b1; flushE = 1'b0; mdOpE = 3'd0;
    srcAE = 32'd1; srcBE = 32'd1; rdE = 5'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stallE); end
    checks++; if (mdDoneE !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", mdDoneE); end
    checks++; if (mdResultE !== 32'h0) begin errors++; $display("FAIL rst_result got %h want 0", mdResultE); end
    checks++; if (mdRdE !== 5'h0) begin errors++; $display("FAIL rst_rd got %h want 0", mdRdE); end
    @(posedge clk); #1;
    mdStartE = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL idle_nostall got %b want 0", stallE); end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [5] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0};
    logic [31:0] as  [5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
    logic [31:0] ex  [5] = '{32'd42, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
    int t0, lat, st;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({5'(i + 1), ex[i]});
      issue(ops[i], as[i], bs[i], 5'(i + 1), t0, lat, st);
      checks++; if (lat != 33) begin errors++; $display("FAIL mul%0d_latency got %0d want 33", i, lat); end
      checks++; if (st != 33) begin errors++; $display("FAIL mul%0d_stalls got %0d want 33", i, st); end
      idle();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int t0, lat, st;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'(i + 10), ex[i]});
      issue(ops[i], as[i], bs[i], 5'(i + 10), t0, lat, st);
      checks++; if (lat != 33) begin errors++; $display("FAIL div%0d_latency got %0d want 33", i, lat); end
      checks++; if (st != 33) begin errors++; $display("FAIL div%0d_stalls got %0d want 33", i, st); end
      idle();
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  ops [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int t0, lat, st;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'(i + 20), ex[i]});
      issue(ops[i], as[i], bs[i], 5'(i + 20), t0, lat, st);
      checks++; if (lat != 1) begin errors++; $display("FAIL fast%0d_latency got %0d want 1", i, lat); end
      checks++; if (st != 1) begin errors++; $display("FAIL fast%0d_stalls got %0d want 1", i, st); end
      idle();
    end
  endtask

  task automatic test_flush();
    int t0, t1, lat, st;
    @(posedge clk); #1;
    mdOpE = 3'd0; srcAE = 32'd11; srcBE = 32'd13; rdE = 5'd3; mdStartE = 1'b1; flushE = 1'b0;
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1 flushE = 1'b1;
    @(negedge clk);
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stallE); end
    @(posedge clk); #1;
    flushE = 1'b0; mdStartE = 1'b0;
    @(negedge clk);
    checks++; if (stallE !== 1'b0 || mdDoneE !== 1'b0) begin
      errors++; $display("FAIL flush_idle got stall=%b done=%b want 0 0", stallE, mdDoneE);
    end
    exp_q.push_back({5'd4, 32'd9});
    issue(3'd0, 32'd3, 32'd3, 5'd4, t1, lat, st);
    checks++; if (t1 - t0 != 12) begin errors++; $display("FAIL flush_restart got T+%0d want T+12", t1 - t0); end
    checks++; if (lat != 33 || cyc - t0 != 45) begin
      errors++; $display("FAIL flush_newop_done got T+%0d want T+45", cyc - t0);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int t0, t1, lat, st, d0;
    d0 = dones;
    exp_q.push_back({5'd6, 32'd3});
    issue(3'd5, 32'd9, 32'd3, 5'd6, t0, lat, st);
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_first got T+%0d want T+33", lat); end
    exp_q.push_back({5'd7, 32'hFFFF_FFFE});
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, t1, lat, st);
    checks++; if (t1 - t0 != 34) begin errors++; $display("FAIL b2b_second_start got T+%0d want T+34", t1 - t0); end
    checks++; if (cyc - t0 != 67) begin errors++; $display("FAIL b2b_second_done got T+%0d want T+67", cyc - t0); end
    idle();
    repeat (3) @(negedge clk);
    checks++; if (dones - d0 != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", dones - d0); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        fst;
    int t0, lat, st;
    for (int i = 0; i < 8; i++) begin
      op  = 3'($urandom_range(7, 0));
      a   = $urandom;
      b   = (i == 3) ? 32'd0 : $urandom;
      fst = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_q.push_back({5'(i + 24), ref_md(op, a, b)});
      issue(op, a, b, 5'(i + 24), t0, lat, st);
      checks++; if (lat != (fst ? 1 : 33)) begin
        errors++; $display("FAIL rand%0d_latency op=%0d got %0d want %0d", i, op, lat, fst ? 1 : 33);
      end
      idle();
    end
  endtask

  task automatic test_mid_reset();
    int t0, d0;
    d0 = dones;
    @(posedge clk); #1;
    mdOpE = 3'd5; srcAE = 32'd100; srcBE = 32'd7; rdE = 5'd9; mdStartE = 1'b1;
    t0 = cyc;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; mdStartE = 1'b0;
    @(negedge clk);
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b want 0", stallE); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({stallE, mdDoneE, mdResultE, mdRdE} !== 39'h0) begin
      errors++; $display("FAIL midrst_outputs T+%0d got stall=%b done=%b res=%h rd=%0d want all 0",
                         cyc - t0, stallE, mdDoneE, mdResultE, mdRdE);
    end
    repeat (40) @(negedge clk);
    checks++; if (dones != d0) begin errors++; $display("FAIL midrst_nodone got %0d pulses want 0", dones - d0); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_back_to_back();
    test_random();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_results got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide engine and sequencer attached to the EX stage of the pipelined RV32I core. It accepts one M-extension operation at a time using the already-forwarded EX operands. It stalls the front of the pipeline while a radix-2 shift-add multiply or restoring divide runs, then presents the result for one cycle so the instruction advances to MEM. Writeback muxing selects `mdResultE` over the ALU result on the done cycle.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mdStartE` in 1: EX holds a valid M-extension instruction.
- `mdOpE` in 3: funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `srcAE` in 32: rs1 after forwarding mux.
- `srcBE` in 32: rs2 after forwarding mux.
- `rdE` in 5: destination register of the EX instruction.
- `flushE` in 1: squash EX (branch taken / redirect).
- `stallE` out 1: hold PC, IF/ID and ID/EX registers.
- `mdDoneE` out 1: one-cycle pulse, result valid.
- `mdResultE` out 32: result, valid only when `mdDoneE`=1.
- `mdRdE` out 5: destination register latched at start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `mdStartE`=1, `flushE`=0:
  - Latch op, rdE, operand signs, operand magnitudes, and the op class (MUL* vs DIV/REM*).
  - Clear the 6-bit counter.
  - Normally go to CALC.
  - Fast path to DONE on divide-by-zero (`srcBE`=0), or signed overflow (DIV/REM with `srcAE`=0x80000000, `srcBE`=0xFFFFFFFF).
- CALC: one bit per cycle for 32 cycles (counter 0..31), then DONE.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring shift-subtract giving a 32-bit quotient and remainder on magnitudes.
- Signedness:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats A as signed, B as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
- DONE: apply sign fixup, drive `mdDoneE`=1 and `mdResultE`, then go to IDLE unconditionally. `mdStartE` is not sampled in DONE.
  - Product is negated if the operand signs differ.
  - MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Fast-path results:
  - Divide by 0: quotient 0xFFFFFFFF, remainder = `srcAE`.
  - Overflow: quotient 0x80000000, remainder 0.
- Stall generation:
  - `stallE` = (IDLE && `mdStartE`) || CALC.
  - `stallE` is forced 0 when `flushE`=1 or `rst`=1.
- Flush: `flushE`=1 in any state sends the FSM to IDLE next cycle with no `mdDoneE` pulse. A start presented together with a flush is ignored.
- Reset:
  - Values: state IDLE, counter 0, `mdDoneE`=0, `mdResultE`=0, `mdRdE`=0, `stallE`=0.
  - Reset mid-operation discards the operation.
- Only one operation is in flight at a time. Non-M instructions (`mdStartE`=0) pass with no stall.

## Timing
- Start accepted at cycle T (IDLE, `mdStartE`=1).
- Normal path:
  - CALC runs T+1..T+32.
  - DONE is at T+33.
  - `stallE` is high T..T+32 (33 cycles) and low at T+33.
- Fast path: `stallE` is high at T only; DONE at T+1.
- On the DONE cycle the stall releases, so the same instruction (still in EX, `mdStartE` still 1) advances to MEM with `mdResultE`.
- A following M instruction in EX at T+34 starts at T+34.
- `mdResultE`/`mdRdE` are registered and stable during DONE. `mdResultE` holds its last value afterwards, but it is qualified only by `mdDoneE`.

## Test plan
- MUL 7×6, start at T: `stallE` high T..T+32; at T+33 `mdDoneE`=1, `mdResultE`=42, `mdRdE`=rdE.
- High-half multiplies:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
  - MUL 0x80000000×0xFFFFFFFF → 0x80000000.
- Divide and remainder:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - All of these have DONE at T+33.
- Fast path:
  - DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
  - Each has `stallE` high only at T and DONE at T+1.
- Flush and reset:
  - `flushE` at T+10: `stallE`=0 at T+10, IDLE at T+11, no `mdDoneE` ever. A new MUL 3×3 at T+12 gives 9 at T+45.
  - `rst` at T+5 gives all outputs 0 at T+6.
- Back-to-back:
  - DIVU 9/3 then MULHU 0xFFFFFFFF×0xFFFFFFFF: `mdStartE` held through DONE at T+33 produces no restart.
  - First result is 3 at T+33; second op starts at T+34 with result 0xFFFFFFFE at T+67.
  - No `mdDoneE` pulses other than T+33 and T+67.
